// File: rtl/pool_stream_ctrl.sv
// Stream sequencer around a 2x2 max-pool stage: forwards raster pixels, tracks position,
// captures window maxima at window-complete positions and buffers them in an output FIFO.
module pool_stream_ctrl #(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned MAP_SIZE   = 28,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic [BIT_WIDTH-1:0] pool_next,
    output logic                 pool_en_n,
    input  logic [BIT_WIDTH-1:0] pool_max,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 frame_done
);

    localparam int unsigned PosW = (MAP_SIZE > 2) ? $clog2(MAP_SIZE) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PosW-1:0] PosMax = PosW'(MAP_SIZE - 1);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW:0]   DepthW = (CntW + 1)'(FIFO_DEPTH);

    logic [PosW-1:0]  col_q, col_d;
    logic [PosW-1:0]  row_q, row_d;
    logic             cap_pend_q, cap_pend_d;
    logic             cap_last_q, cap_last_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [BIT_WIDTH:0] mem_q [FIFO_DEPTH];
    logic [BIT_WIDTH:0] mem_d [FIFO_DEPTH];

    logic            acc;
    logic            push;
    logic            pop;
    logic [CntW:0]   occ;

    // Occupancy includes the pending capture so a capture can never find the FIFO full.
    always_comb begin
        occ       = {1'b0, count_q} + {{CntW{1'b0}}, cap_pend_q};
        in_ready  = !clr && (occ < DepthW);
        acc       = in_valid && in_ready;
        pool_next = in_data;
        pool_en_n = !acc;
    end

    always_comb begin
        out_valid  = (count_q != '0);
        push       = cap_pend_q && !clr;
        pop        = out_valid && out_ready && !clr;
        frame_done = push && cap_last_q;
        out_data   = out_valid ? mem_q[rd_ptr_q][BIT_WIDTH-1:0] : '0;
        out_last   = out_valid && mem_q[rd_ptr_q][BIT_WIDTH];
    end

    // Raster position and capture scheduling.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        cap_pend_d = 1'b0;
        cap_last_d = 1'b0;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (acc) begin
            if (col_q == PosMax) begin
                col_d = '0;
                row_d = (row_q == PosMax) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (row_q[0] && col_q[0]) begin
                cap_pend_d = 1'b1;
                cap_last_d = (row_q == PosMax) && (col_q == PosMax);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {cap_last_q, pool_max};
                wr_ptr_d        = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            cap_pend_q <= 1'b0;
            cap_last_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            cap_pend_q <= cap_pend_d;
            cap_last_q <= cap_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && ({1'b0, count_q} == DepthW)));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        ({1'b0, count_q} <= DepthW));

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// Scoreboard bench for pool_stream_ctrl: two instances (FIFO depth 4 and 2) each wrapped
// around a behavioural 2x2 max-pool window; expected pooled values come from the pixel table.
`timescale 1ns/1ps
module tb_pool_stream_ctrl;

    localparam int BW     = 32;
    localparam int M      = 4;
    localparam int NPix   = M * M;
    localparam int WinLen = M + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [BW-1:0] in_data;
    logic          out_ready;

    logic [1:0]    in_valid_v;
    logic [1:0]    in_ready_v;
    logic [1:0]    pool_en_n_v;
    logic [1:0]    out_valid_v;
    logic [1:0]    out_last_v;
    logic [1:0]    frame_done_v;
    logic [BW-1:0] pool_next_v [2];
    logic [BW-1:0] out_data_v  [2];

    int            sel;
    logic [BW:0]   exp_q [$];
    logic [BW:0]   exp_e;
    int            n_checks;
    int            n_pass;
    int            en_low_cnt;
    int            fd_cnt;
    int            acc_cnt;
    int            pix [NPix];
    logic          tog_done;

    logic          o_in_ready, o_out_valid, o_out_last, o_frame_done, o_pool_en_n;
    logic [BW-1:0] o_out_data;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic signed [BW-1:0] win_q [WinLen];
        logic signed [BW-1:0] bot_max, top_max, pmax;

        // Window taps: [0]=(r,c) [1]=(r,c-1) [M]=(r-1,c) [M+1]=(r-1,c-1).
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < WinLen; i++) win_q[i] <= '0;
            end else if (!pool_en_n_v[g]) begin
                win_q[0] <= pool_next_v[g];
                for (int i = 1; i < WinLen; i++) win_q[i] <= win_q[i-1];
            end
        end

        always_comb begin
            bot_max = (win_q[0] > win_q[1]) ? win_q[0] : win_q[1];
            top_max = (win_q[M] > win_q[M+1]) ? win_q[M] : win_q[M+1];
            pmax    = (bot_max > top_max) ? bot_max : top_max;
        end

        pool_stream_ctrl #(
            .BIT_WIDTH (BW),
            .MAP_SIZE  (M),
            .FIFO_DEPTH((g == 0) ? 4 : 2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data),
            .pool_next (pool_next_v[g]),
            .pool_en_n (pool_en_n_v[g]),
            .pool_max  (pmax),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out_data  (out_data_v[g]),
            .out_last  (out_last_v[g]),
            .frame_done(frame_done_v[g])
        );
    end

    always_comb begin
        o_in_ready   = in_ready_v[sel];
        o_out_valid  = out_valid_v[sel];
        o_out_last   = out_last_v[sel];
        o_frame_done = frame_done_v[sel];
        o_pool_en_n  = pool_en_n_v[sel];
        o_out_data   = out_data_v[sel];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    // Output monitor: pops the scoreboard on every accepted output.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            if (!o_pool_en_n) en_low_cnt++;
            if (o_frame_done) fd_cnt++;
            if (o_out_valid && out_ready) begin
                check("sb_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("out_data", 64'(o_out_data), 64'(exp_e[BW-1:0]));
                    check("out_last", 64'(o_out_last), 64'(exp_e[BW]));
                end
            end
        end
    end

    function automatic logic [BW:0] win_exp(input int r, input int c);
        int   m;
        logic lst;
        m = pix[r*M + c];
        if (pix[r*M + c - 1] > m) m = pix[r*M + c - 1];
        if (pix[(r-1)*M + c] > m) m = pix[(r-1)*M + c];
        if (pix[(r-1)*M + c - 1] > m) m = pix[(r-1)*M + c - 1];
        lst = (r == M - 1) && (c == M - 1);
        return {lst, m[BW-1:0]};
    endfunction

    task automatic send_pixel(input int idx);
        logic rdy;
        int   waited;
        int   r;
        int   c;
        rdy    = 1'b0;
        waited = 0;
        while (!rdy && waited < 200) begin
            @(negedge clk);
            in_valid_v[sel] = 1'b1;
            in_data         = pix[idx];
            #1 rdy = o_in_ready;
            waited++;
        end
        if (!rdy) begin
            check("accept_timeout", 64'(rdy), 64'd1);
            return;
        end
        @(posedge clk);
        acc_cnt++;
        r = idx / M;
        c = idx % M;
        if ((r % 2 == 1) && (c % 2 == 1)) exp_q.push_back(win_exp(r, c));
    endtask

    task automatic send_map(input int kind, input int upto);
        for (int i = 0; i < NPix; i++) pix[i] = (kind == 0) ? i : -(i + 1);
        for (int i = 0; i < upto; i++) send_pixel(i);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid_v = '0;
    endtask

    task automatic drain(input string tag);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 64'(o_in_ready), 64'd1);
        check("rst_out_valid", 64'(o_out_valid), 64'd0);
        check("rst_out_data", 64'(o_out_data), 64'd0);
        check("rst_out_last", 64'(o_out_last), 64'd0);
        check("rst_frame_done", 64'(o_frame_done), 64'd0);
        check("rst_pool_en_n", 64'(o_pool_en_n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        clr        = 1'b0;
        in_valid_v = '0;
        in_data    = '0;
        out_ready  = 1'b1;
        sel        = 0;
        n_checks   = 0;
        n_pass     = 0;
        en_low_cnt = 0;
        fd_cnt     = 0;
        acc_cnt    = 0;
        tog_done   = 1'b0;

        repeat (2) @(negedge clk);
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Ramp map: 5, 7, 13, 15 with last on 15.
        en_low_cnt = 0;
        fd_cnt     = 0;
        send_map(0, NPix);
        idle();
        drain("ramp_drain");
        check("ramp_en_cycles", 64'(en_low_cnt), 64'd16);
        check("ramp_frame_done", 64'(fd_cnt), 64'd1);

        // Negative map: -1, -3, -9, -11.
        fd_cnt = 0;
        send_map(1, NPix);
        idle();
        drain("neg_drain");
        check("neg_frame_done", 64'(fd_cnt), 64'd1);

        // Two ramp maps with out_ready toggling every cycle.
        fd_cnt   = 0;
        tog_done = 1'b0;
        fork
            begin
                send_map(0, NPix);
                send_map(0, NPix);
                idle();
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    @(negedge clk);
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        drain("toggle_drain");
        check("toggle_frame_done", 64'(fd_cnt), 64'd2);

        // Reset after pixel 6, then a clean ramp.
        send_map(0, 7);
        @(negedge clk);
        rst        = 1'b0;
        in_valid_v = '0;
        exp_q.delete();
        #2 check_reset_outputs();
        @(negedge clk);
        #1 check("rst_hold_out_valid", 64'(o_out_valid), 64'd0);
        @(negedge clk);
        rst    = 1'b1;
        fd_cnt = 0;
        send_map(0, NPix);
        idle();
        drain("rst_drain");
        check("rst_frame_done", 64'(fd_cnt), 64'd1);

        // clr one cycle after the window-completing pixel 5.
        fd_cnt = 0;
        send_map(0, 6);
        @(negedge clk);
        clr             = 1'b1;
        in_valid_v[sel] = 1'b1;
        in_data         = 32'd99;
        void'(exp_q.pop_back());
        #1;
        check("clr_in_ready", 64'(o_in_ready), 64'd0);
        check("clr_pool_en_n", 64'(o_pool_en_n), 64'd1);
        check("clr_frame_done", 64'(o_frame_done), 64'd0);
        @(negedge clk);
        clr        = 1'b0;
        in_valid_v = '0;
        repeat (3) begin
            @(negedge clk);
            #1 check("clr_no_write", 64'(o_out_valid), 64'd0);
        end
        send_map(0, NPix);
        idle();
        drain("clr_drain");
        check("clr_frame_done_total", 64'(fd_cnt), 64'd1);

        // Backpressure on the depth-2 instance across two maps.
        @(negedge clk);
        sel       = 1;
        out_ready = 1'b0;
        fd_cnt    = 0;
        acc_cnt   = 0;
        fork
            begin
                send_map(0, NPix);
                send_map(0, NPix);
                idle();
            end
            begin
                repeat (40) @(negedge clk);
                #1;
                check("bp_in_ready", 64'(o_in_ready), 64'd0);
                check("bp_out_valid", 64'(o_out_valid), 64'd1);
                check("bp_accepted", 64'(acc_cnt), 64'd8);
                check("bp_pending", 64'(exp_q.size()), 64'd2);
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_frame_done", 64'(fd_cnt), 64'd2);
        check("bp_total_accepted", 64'(acc_cnt), 64'd32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pool_stream_ctrl.md
Name: pool_stream_ctrl

Overview:
- Stream sequencer wrapped around the 2x2 max-pool stage of a LeNet-5 feature-map pipeline.
- Accepts a raster-order pixel stream (valid/ready) from the conv/activation stage and forwards each pixel to the pool stage.
- Drives the pool stage's active-low shift enable and tracks row/column position.
- Captures the pool stage's max output only at 2x2 window-complete positions and presents the pooled map downstream through a small FIFO with valid/ready and an end-of-map marker.

Parameters:
- BIT_WIDTH, 32, signed pixel/data width.
- MAP_SIZE, 28, input map width and height; must be even and at least 2.
- FIFO_DEPTH, 4, output FIFO entries; must be at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear: counters, capture flag and FIFO to reset state.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  BIT_WIDTH  upstream pixel, signed.
- pool_next  output  BIT_WIDTH  pixel to pool stage; equals in_data, combinational.
- pool_en_n  output  1  pool-stage shift enable, active low; 0 exactly when in_valid && in_ready.
- pool_max  input  BIT_WIDTH  pool-stage 2x2 max, combinational from its window.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  BIT_WIDTH  FIFO head data.
- out_last  output  1  head entry is the final pooled value of a map.
- frame_done  output  1  one-cycle pulse when the last pooled value of a map is written into the FIFO.

Behaviour:
- Accept: a pixel is accepted when acc = in_valid && in_ready. The pool stage shifts on that same edge.
- Counters: col and row are each $clog2(MAP_SIZE) bits and reset to 0. On acc, col increments. When col reaches MAP_SIZE-1 it wraps to 0 and row increments. When row reaches MAP_SIZE-1 at col MAP_SIZE-1, both wrap to 0. No idle cycles or handshake are needed between maps.
- Window timing: after the pool stage shifts on pixel (r,c), its window holds (r,c), (r,c-1), (r-1,c) and (r-1,c-1). pool_max is valid during the cycle after the accepting edge.
- Capture: on acc with row odd and col odd, set cap_pend. Also set cap_last if row == MAP_SIZE-1 and col == MAP_SIZE-1.
- FIFO write: in the next cycle, when cap_pend = 1, write {cap_last, pool_max} into the FIFO and clear cap_pend. frame_done = 1 in that cycle iff cap_last = 1.
- Latency: from acceptance of window-completing pixel to out_valid is 2 cycles, assuming the FIFO was empty.
- Capture/accept overlap: cap_pend can only be set on odd columns and clears in the following cycle. A new capture therefore never overlaps a pending one.
- Backpressure: in_ready = (count + cap_pend) < FIFO_DEPTH, where count is FIFO occupancy. This is conservative: an out_ready pop in the same cycle is ignored. A capture never finds the FIFO full.
- Non-capture pixels: accepting a pixel that does not complete a window never writes the FIFO. It is still gated by in_ready; no separate bypass path exists.
- FIFO pop: occurs when out_valid && out_ready. Simultaneous push and pop keeps count unchanged and preserves order. A pop when empty is ignored.
- FIFO storage: circular buffer with wrap-around read/write pointers.
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, frame_done = 0, pool_en_n = 1 while in_valid = 0. Counters, pointers, count, cap_pend and cap_last are all 0.
- rst mid-map: all state is lost immediately and the next accepted pixel is (0,0). The pool stage shares rst.
- clr: same effect as reset, but synchronous. A capture pending at clr is discarded. clr has priority over acc, and acc is blocked in a clr cycle (in_ready = 0).
- Arithmetic: none on data. pool_max is stored unmodified and sign is preserved.

Test Plan:
- Ramp map: MAP_SIZE=4, FIFO_DEPTH=4, in_data = 0..15, in_valid held high, out_ready high. Required: out_data sequence 5, 7, 13, 15; out_last only on 15; one frame_done pulse; pool_en_n low for exactly 16 cycles.
- Negative values: MAP_SIZE=4, pixels = -(index+1). Required: outputs -1, -3, -9, -11, confirming signed max via pool stage.
- Backpressure: out_ready = 0 through two maps with MAP_SIZE=4 and FIFO_DEPTH=2. Required: in_ready drops once count + cap_pend = 2 and no FIFO overflow. Release out_ready; all 8 values then arrive in order.
- Simultaneous push/pop: out_ready toggling every cycle during ramp maps. Required: count never exceeds FIFO_DEPTH, read/write pointers wrap correctly, no loss or duplication.
- Reset mid-map: assert rst after pixel 6 of the ramp, then restart the ramp. Required: outputs are still 5, 7, 13, 15 with no stale entry; all outputs are at reset values while rst = 0.
- clr with capture pending: assert clr in the cycle after pixel 5 is accepted. Required: no FIFO write and no frame_done; the next pixel restarts at (0,0).
